// File: rtl/shared_mem_pkg.sv
// Purpose: shared constants for the dual-core shared-memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package shared_mem_pkg;

    // Default widths
    localparam int DEF_ADDR_W   = 32;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_LOCK_MAX = 16;
    localparam int DEF_CNT_W    = 16;

    // Lock age counter is wide enough for the largest legal LOCK_MAX (255)
    localparam int LOCK_CNT_W   = 8;

    // Core identifiers
    localparam logic CORE0 = 1'b0;
    localparam logic CORE1 = 1'b1;

    // Arbiter state encoding
    localparam logic [1:0] ST_OPEN     = 2'd0;
    localparam logic [1:0] ST_LOCKED_0 = 2'd1;
    localparam logic [1:0] ST_LOCKED_1 = 2'd2;

endpackage

// File: rtl/rr_grant2.sv
// Purpose: two-input round-robin grant picker, one-hot output.
// Latency: combinational.
// Backpressure: a lone request always wins; on a tie the core that did not win last time wins.
module rr_grant2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    // last == 1 means core 1 won most recently, so core 0 takes the tie
    assign gnt[0] = req[0] & (~req[1] | last);
    assign gnt[1] = req[1] & (~req[0] | ~last);

endmodule

// File: rtl/shared_mem_arbiter.sv
// Purpose: shares one synchronous single-port memory between two cores, round-robin with optional lock.
// Latency: grant is combinational in the request cycle; read data returns on rvalid one cycle later.
// Backpressure: an un-granted request stalls (requester holds it); a lock is force-released after LOCK_MAX cycles.
module shared_mem_arbiter
    import shared_mem_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int LOCK_MAX = DEF_LOCK_MAX,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              c0_req,
    input  logic [ADDR_W-1:0] c0_addr,
    input  logic              c0_write,
    input  logic [DATA_W-1:0] c0_wdata,
    input  logic              c0_lock,
    output logic              c0_gnt,
    output logic [DATA_W-1:0] c0_rdata,
    output logic              c0_rvalid,
    input  logic              c1_req,
    input  logic [ADDR_W-1:0] c1_addr,
    input  logic              c1_write,
    input  logic [DATA_W-1:0] c1_wdata,
    input  logic              c1_lock,
    output logic              c1_gnt,
    output logic [DATA_W-1:0] c1_rdata,
    output logic              c1_rvalid,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              lock_timeout,
    output logic [CNT_W-1:0]  contention_cnt
);

    logic [1:0]            state_q, state_d;
    logic                  last_q, last_d;
    logic [LOCK_CNT_W-1:0] lock_cnt_q, lock_cnt_d;
    logic                  timeout_q, timeout_d;
    logic                  c0_rvalid_q, c1_rvalid_q;
    logic [DATA_W-1:0]     c0_rdata_q, c1_rdata_q;
    logic [CNT_W-1:0]      cont_q;

    logic [1:0] rr_gnt;
    logic [1:0] gnt_raw;
    logic [1:0] gnt;
    logic       owner;
    logic       own_req;
    logic       own_lock;
    logic       stall;

    rr_grant2 u_rr (
        .req  ({c1_req, c0_req}),
        .last (last_q),
        .gnt  (rr_gnt)
    );

    assign owner    = (state_q == ST_LOCKED_1) ? CORE1 : CORE0;
    assign own_req  = (owner == CORE1) ? c1_req  : c0_req;
    assign own_lock = (owner == CORE1) ? c1_lock : c0_lock;

    // Grant selection and lock FSM next state
    always_comb begin
        gnt_raw    = 2'b00;
        state_d    = state_q;
        last_d     = last_q;
        lock_cnt_d = lock_cnt_q;
        timeout_d  = 1'b0;
        case (state_q)
            ST_OPEN: begin
                gnt_raw = rr_gnt;
                if (rr_gnt[1]) begin
                    last_d = CORE1;
                    if (c1_lock) begin
                        state_d    = ST_LOCKED_1;
                        lock_cnt_d = LOCK_CNT_W'(1);
                    end
                end else if (rr_gnt[0]) begin
                    last_d = CORE0;
                    if (c0_lock) begin
                        state_d    = ST_LOCKED_0;
                        lock_cnt_d = LOCK_CNT_W'(1);
                    end
                end
            end
            ST_LOCKED_0, ST_LOCKED_1: begin
                if (lock_cnt_q == LOCK_CNT_W'(LOCK_MAX)) begin
                    // Forced release: the owner gets nothing this cycle and loses the next tie
                    state_d    = ST_OPEN;
                    last_d     = owner;
                    lock_cnt_d = '0;
                    timeout_d  = 1'b1;
                end else begin
                    lock_cnt_d = lock_cnt_q + LOCK_CNT_W'(1);
                    if (own_req) begin
                        gnt_raw = (owner == CORE1) ? 2'b10 : 2'b01;
                    end
                    // Lock drops on a final unlocked access or when the owner idles with lock low
                    if (!own_lock) begin
                        state_d    = ST_OPEN;
                        lock_cnt_d = '0;
                    end
                end
            end
            default: state_d = ST_OPEN;
        endcase
    end

    // No grant can escape while reset is held low
    assign gnt    = gnt_raw & {2{reset}};
    assign c0_gnt = gnt[0];
    assign c1_gnt = gnt[1];
    assign mem_en = gnt[0] | gnt[1];

    // Memory port mux of the granted core, zero when idle
    always_comb begin
        mem_addr  = '0;
        mem_write = 1'b0;
        mem_wdata = '0;
        if (gnt[0]) begin
            mem_addr  = c0_addr;
            mem_write = c0_write;
            mem_wdata = c0_wdata;
        end else if (gnt[1]) begin
            mem_addr  = c1_addr;
            mem_write = c1_write;
            mem_wdata = c1_wdata;
        end
    end

    assign stall = (c0_req & ~gnt[0]) | (c1_req & ~gnt[1]);

    // Lock FSM, round-robin pointer and timeout pulse
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_OPEN;
            last_q     <= CORE1;
            lock_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            lock_cnt_q <= lock_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    // Read return routing: per-core tag of who issued last cycle's read, plus held read data
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            c0_rvalid_q <= 1'b0;
            c1_rvalid_q <= 1'b0;
            c0_rdata_q  <= '0;
            c1_rdata_q  <= '0;
        end else begin
            c0_rvalid_q <= gnt[0] & ~c0_write;
            c1_rvalid_q <= gnt[1] & ~c1_write;
            if (c0_rvalid_q) c0_rdata_q <= mem_rdata;
            if (c1_rvalid_q) c1_rdata_q <= mem_rdata;
        end
    end

    // Saturating count of cycles with at least one stalled request
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cont_q <= '0;
        end else if (stall && (cont_q != {CNT_W{1'b1}})) begin
            cont_q <= cont_q + CNT_W'(1);
        end
    end

    // Memory data arrives the cycle after the strobe, so pass it straight through on rvalid
    assign c0_rvalid      = c0_rvalid_q;
    assign c1_rvalid      = c1_rvalid_q;
    assign c0_rdata       = c0_rvalid_q ? mem_rdata : c0_rdata_q;
    assign c1_rdata       = c1_rvalid_q ? mem_rdata : c1_rdata_q;
    assign lock_timeout   = timeout_q;
    assign contention_cnt = cont_q;

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Purpose: self-checking bench for shared_mem_arbiter with directed steps and a randomized run.
// Latency: reference model predicts grants in-cycle and read returns one cycle later.
// Backpressure: bench requesters hold each request until granted.
module tb_shared_mem_arbiter;

    localparam int LMAX = 4;
    localparam int CW   = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic        clock = 1'b0;
    logic        reset;
    logic        c0_req, c0_write, c0_lock, c0_gnt, c0_rvalid;
    logic [31:0] c0_addr, c0_wdata, c0_rdata;
    logic        c1_req, c1_write, c1_lock, c1_gnt, c1_rvalid;
    logic [31:0] c1_addr, c1_wdata, c1_rdata;
    logic        mem_en, mem_write, lock_timeout;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic [CW-1:0] contention_cnt;

    int n_checks = 0;
    int n_errors = 0;

    shared_mem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .LOCK_MAX(LMAX), .CNT_W(CW)
    ) dut (
        .clock(clock), .reset(reset),
        .c0_req(c0_req), .c0_addr(c0_addr), .c0_write(c0_write), .c0_wdata(c0_wdata),
        .c0_lock(c0_lock), .c0_gnt(c0_gnt), .c0_rdata(c0_rdata), .c0_rvalid(c0_rvalid),
        .c1_req(c1_req), .c1_addr(c1_addr), .c1_write(c1_write), .c1_wdata(c1_wdata),
        .c1_lock(c1_lock), .c1_gnt(c1_gnt), .c1_rdata(c1_rdata), .c1_rvalid(c1_rvalid),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_write(mem_write), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .lock_timeout(lock_timeout), .contention_cnt(contention_cnt)
    );

    always #5 clock = ~clock;

    // Synchronous single-port memory: one-cycle read latency, write at the edge
    logic [31:0] mem [int];

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        int k;
        k = int'(a[7:0]);
        return mem.exists(k) ? mem[k] : 32'h0;
    endfunction

    always @(posedge clock) begin
        if (mem_en) begin
            if (mem_write) mem[int'(mem_addr[7:0])] = mem_wdata;
            else           mem_rdata <= mem_read(mem_addr);
        end
    end

    // Reference model state: lock owner (-1 = none), lock age, last winner, counters
    int          m_owner, m_last, m_age, m_cnt;
    logic        m_rv0, m_rv1, m_tmo;
    logic [31:0] m_rd0, m_rd1;
    logic        s_g0, s_g1;
    logic [31:0] s_mwd;

    task automatic model_reset();
        m_owner = -1; m_last = 1; m_age = 0; m_cnt = 0;
        m_rv0 = 0; m_rv1 = 0; m_tmo = 0; m_rd0 = 0; m_rd1 = 0;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set0(input logic r, input logic [31:0] a, input logic w, input logic [31:0] d, input logic l);
        c0_req = r; c0_addr = a; c0_write = w; c0_wdata = d; c0_lock = l;
    endtask

    task automatic set1(input logic r, input logic [31:0] a, input logic w, input logic [31:0] d, input logic l);
        c1_req = r; c1_addr = a; c1_write = w; c1_wdata = d; c1_lock = l;
    endtask

    // One clock cycle: compare every output with the model mid-cycle, then advance the model
    task automatic tick();
        logic eg0, eg1, tmo_now, own_lock;
        logic [31:0] ea, ed;
        logic ew;
        @(negedge clock);
        eg0 = 0; eg1 = 0; tmo_now = 0;
        if (m_owner < 0) begin
            if (c0_req && c1_req) begin
                if (m_last == 1) eg0 = 1; else eg1 = 1;
            end else begin
                eg0 = c0_req; eg1 = c1_req;
            end
        end else if (m_age == LMAX) begin
            tmo_now = 1;
        end else if (m_owner == 0) begin
            eg0 = c0_req;
        end else begin
            eg1 = c1_req;
        end
        ea = eg0 ? c0_addr  : (eg1 ? c1_addr  : 32'h0);
        ew = eg0 ? c0_write : (eg1 ? c1_write : 1'b0);
        ed = eg0 ? c0_wdata : (eg1 ? c1_wdata : 32'h0);
        s_g0 = c0_gnt; s_g1 = c1_gnt; s_mwd = mem_wdata;
        check("c0_gnt", c0_gnt, eg0);
        check("c1_gnt", c1_gnt, eg1);
        check("mem_en", mem_en, eg0 | eg1);
        check("mem_addr", mem_addr, ea);
        check("mem_write", mem_write, ew);
        check("mem_wdata", mem_wdata, ed);
        check("c0_rvalid", c0_rvalid, m_rv0);
        check("c1_rvalid", c1_rvalid, m_rv1);
        check("c0_rdata", c0_rdata, m_rd0);
        check("c1_rdata", c1_rdata, m_rd1);
        check("lock_timeout", lock_timeout, m_tmo);
        check("contention_cnt", contention_cnt, m_cnt);
        // Advance model to the next cycle
        if (((c0_req && !eg0) || (c1_req && !eg1)) && m_cnt < CMAX) m_cnt++;
        m_tmo = tmo_now;
        m_rv0 = eg0 && !c0_write;
        m_rv1 = eg1 && !c1_write;
        if (m_rv0) m_rd0 = mem_read(c0_addr);
        if (m_rv1) m_rd1 = mem_read(c1_addr);
        if (tmo_now) begin
            m_last = m_owner; m_owner = -1; m_age = 0;
        end else if (m_owner >= 0) begin
            own_lock = (m_owner == 0) ? c0_lock : c1_lock;
            m_age++;
            if (!own_lock) m_owner = -1;
        end else if (eg0 || eg1) begin
            m_last = eg1 ? 1 : 0;
            if (eg1 ? c1_lock : c0_lock) begin
                m_owner = eg1 ? 1 : 0; m_age = 1;
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        model_reset();
        set0(1, 32'h4, 0, 0, 1);
        set1(1, 32'h8, 1, 32'h9, 1);
        #3;
        // Reset state with both cores requesting
        check("rst_c0_gnt", c0_gnt, 0);
        check("rst_c1_gnt", c1_gnt, 0);
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_c0_rvalid", c0_rvalid, 0);
        check("rst_c1_rdata", c1_rdata, 0);
        check("rst_timeout", lock_timeout, 0);
        check("rst_cnt", contention_cnt, 0);
        set0(0, 0, 0, 0, 0);
        set1(0, 0, 0, 0, 0);
        do_reset();

        // Single requester: preload 0x10, then read it back
        set0(1, 32'h10, 1, 32'hDEADBEEF, 0);
        tick();
        set0(1, 32'h10, 0, 0, 0);
        tick();
        check("t1_gnt_same_cycle", s_g0, 1);
        set0(0, 0, 0, 0, 0);
        check("t1_rvalid", c0_rvalid, 1);
        check("t1_rdata", c0_rdata, 32'hDEADBEEF);
        check("t1_c1_rvalid", c1_rvalid, 0);
        check("t1_cnt", contention_cnt, 0);
        tick();

        // Simultaneous same-address writes serialise by grant order
        do_reset();
        set0(1, 32'h20, 1, 32'h1, 0);
        set1(1, 32'h20, 1, 32'h2, 0);
        tick();
        check("t2_first_c0", s_g0, 1);
        check("t2_first_c1", s_g1, 0);
        check("t2_first_wdata", s_mwd, 32'h1);
        set0(0, 0, 0, 0, 0);
        tick();
        check("t2_second_c1", s_g1, 1);
        check("t2_second_wdata", s_mwd, 32'h2);
        set1(0, 0, 0, 0, 0);
        check("t2_cnt", contention_cnt, 1);
        set0(1, 32'h20, 0, 0, 0);
        tick();
        set0(0, 0, 0, 0, 0);
        check("t2_last_writer", c0_rdata, 32'h2);
        tick();

        // Continuous dual requests alternate
        do_reset();
        set0(1, 32'h1, 0, 0, 0);
        set1(1, 32'h2, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("t3_alt_c0", s_g0, (i % 2) == 0);
            check("t3_alt_c1", s_g1, (i % 2) == 1);
        end
        set0(0, 0, 0, 0, 0);
        set1(0, 0, 0, 0, 0);
        tick();

        // Locked read-modify-write holds off core 1 for two cycles
        do_reset();
        set0(1, 32'h30, 0, 0, 1);
        set1(1, 32'h40, 0, 0, 0);
        tick();
        check("t4_rmw_rd_c0", s_g0, 1);
        check("t4_rmw_rd_c1", s_g1, 0);
        set0(1, 32'h30, 1, 32'h55, 0);
        tick();
        check("t4_rmw_wr_c0", s_g0, 1);
        check("t4_rmw_wr_c1", s_g1, 0);
        set0(0, 0, 0, 0, 0);
        tick();
        check("t4_c1_after", s_g1, 1);
        check("t4_no_timeout", lock_timeout, 0);
        set1(0, 0, 0, 0, 0);
        tick();

        // Lock timeout with idle owner holding lock high
        do_reset();
        set0(1, 32'h50, 0, 0, 1);
        set1(1, 32'h60, 1, 32'h7, 0);
        tick();
        check("t5_lock_gnt", s_g0, 1);
        set0(0, 0, 0, 0, 1);
        for (int i = 0; i < LMAX; i++) begin
            tick();
            check("t5_c1_stalled", s_g1, 0);
        end
        check("t5_timeout_pulse", lock_timeout, 1);
        check("t5_c1_granted", c1_gnt, 1);
        tick();
        set1(0, 0, 0, 0, 0);
        set0(0, 0, 0, 0, 0);
        check("t5_pulse_ends", lock_timeout, 0);
        tick();

        // Asynchronous reset mid-lock with a read in flight
        do_reset();
        set0(1, 32'h10, 0, 0, 1);
        set1(1, 32'h70, 0, 0, 0);
        tick();
        check("t6_inflight", c0_rvalid, 1);
        #2 reset = 1'b0;
        #1;
        check("t6_c0_gnt", c0_gnt, 0);
        check("t6_c1_gnt", c1_gnt, 0);
        check("t6_mem_en", mem_en, 0);
        check("t6_mem_addr", mem_addr, 0);
        check("t6_c0_rvalid", c0_rvalid, 0);
        check("t6_c0_rdata", c0_rdata, 0);
        check("t6_cnt", contention_cnt, 0);
        model_reset();
        @(posedge clock);
        #1 reset = 1'b1;
        set0(1, 32'h10, 0, 0, 0);
        tick();
        check("t6_first_tie_c0", s_g0, 1);
        set0(0, 0, 0, 0, 0);
        set1(0, 0, 0, 0, 0);
        tick();

        // Randomized traffic against the reference model
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if (!c0_req || s_g0) begin
                if ($urandom_range(0, 9) < 8)
                    set0(1, $urandom_range(0, 15), $urandom_range(0, 1), $urandom, $urandom_range(0, 3) == 0);
                else
                    set0(0, 0, 0, 0, $urandom_range(0, 3) == 0);
            end
            if (!c1_req || s_g1) begin
                if ($urandom_range(0, 9) < 8)
                    set1(1, $urandom_range(0, 15), $urandom_range(0, 1), $urandom, $urandom_range(0, 3) == 0);
                else
                    set1(0, 0, 0, 0, $urandom_range(0, 3) == 0);
            end
            tick();
        end
        check("rand_cnt_saturated", contention_cnt, CMAX);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/shared_mem_arbiter.md
Name: shared_mem_arbiter

Overview:
- Two-requester arbiter that shares the single-port shared data memory between core 0 and core 1 of the dual-core CPU.
- Arbitration is round-robin, with an optional lock that holds ownership for atomic read-modify-write sequences.
- A lock timeout guarantees forward progress for the other core.
- Sits between the two cores' data-memory ports and the shared memory.
- The shared memory is synchronous: one-cycle read latency, write committed at the clock edge.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- LOCK_MAX, 16, maximum consecutive cycles a lock may be held before a forced release (legal range 1..255).
- CNT_W, 16, width of the contention counter.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- c0_req  in  1  core 0 access request.
- c0_addr  in  ADDR_W  core 0 address.
- c0_write  in  1  core 0 write enable (0 = read).
- c0_wdata  in  DATA_W  core 0 write data.
- c0_lock  in  1  core 0 requests ownership be kept after this access.
- c0_gnt  out  1  core 0 access accepted this cycle.
- c0_rdata  out  DATA_W  core 0 read data.
- c0_rvalid  out  1  c0_rdata valid (one-cycle pulse).
- c1_req, c1_addr, c1_write, c1_wdata, c1_lock, c1_gnt, c1_rdata, c1_rvalid: same as core 0, for core 1.
- mem_en  out  1  memory access strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_write  out  1  memory write enable.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid the cycle after a read strobe.
- lock_timeout  out  1  one-cycle pulse when a lock is forcibly released.
- contention_cnt  out  CNT_W  saturating count of cycles in which a request was stalled.

Behaviour:
- Reset (reset low, asynchronous) forces:
  - state = OPEN, last_grant = 1 (core 0 wins first tie), lock counter = 0.
  - c*_rvalid = 0, c*_rdata = 0, lock_timeout = 0, contention_cnt = 0.
  - Grants and mem_en read 0 while reset is low.
- Grant logic is combinational from the registered state and the current requests.
  - mem_* is the mux of the granted core's inputs.
  - mem_en = c0_gnt | c1_gnt; the two grants are never high together.
  - With no grant, mem_addr, mem_write and mem_wdata are driven 0.
- A requester holds req, addr, write, wdata and lock stable until it sees gnt. An un-granted request is a stall.
- States:
  - OPEN:
    - A single request is granted.
    - If both cores request, grant the core != last_grant. last_grant updates to the granted core.
    - If the granted access has lock=1, next state is LOCKED_x (x = granted core) and the lock counter loads 1.
  - LOCKED_x:
    - Only core x may be granted; the other core stalls even if core x is idle.
    - The lock counter increments every cycle while in LOCKED_x.
    - Exit to OPEN when core x makes a granted access with lock=0. That final access is itself granted.
    - Exit to OPEN when core x is idle with its lock input low.
    - Exit to OPEN on timeout: counter == LOCK_MAX at a clock edge. Then lock_timeout pulses for one cycle, last_grant = x, and no grant to core x is issued on the timeout cycle.
    - A granted access with lock=1 in LOCKED_x stays locked and does not reload the counter.
- Read return:
  - A granted read in cycle N gives c*_rvalid = 1 in N+1, with c*_rdata = mem_rdata, registered to the owning core.
  - The non-owning core sees rvalid 0 and rdata held at its last value.
  - Writes produce no rvalid.
  - Back-to-back grants to either core are allowed every cycle. The N+1 return is routed by a registered owner tag, independent of the N+1 grant.
- contention_cnt increments by 1 for each cycle in which any c*_req is high with its gnt low, and saturates at all-ones.
- Same-address simultaneous writes are serialised: the first grant commits, the second commits the following cycle (last-writer-wins by grant order).
- If reset is asserted mid-lock, the lock is dropped and any in-flight rvalid is suppressed.

Decomposition:
- Shared package shared_mem_pkg holds:
  - state encoding (OPEN, LOCKED_0, LOCKED_1);
  - core id constants CORE0 = 0, CORE1 = 1;
  - default widths.
- One sub-module: rr_grant2, the 2-input round-robin grant picker (inputs req[1:0] and last; output onehot gnt[1:0]).
- Lock FSM, read-return routing and counters stay in the top module.

Test Plan:
- Single requester: c0 read at 0x10, memory returns 0xDEADBEEF -> c0_gnt=1 in the same cycle; next cycle c0_rvalid=1 with c0_rdata=0xDEADBEEF; c1_rvalid=0; contention_cnt=0.
- Both cores write 0x20 in the same cycle after reset (c0 data 0x1, c1 data 0x2) -> c0 granted in cycle N, c1 in N+1; mem_wdata sequence 0x1 then 0x2; contention_cnt=1.
- Continuous dual requests for 6 cycles -> grants alternate 0,1,0,1,0,1; never both high.
- c0 lock RMW: read 0x30 with lock=1, then write 0x30 with lock=0 while c1 requests throughout -> c1 stalled for 2 cycles, then granted; no lock_timeout.
- Lock timeout, LOCK_MAX=4: c0 holds lock=1 with req=0 while c1 requests -> lock_timeout pulses after 4 locked cycles; c1 granted on the next cycle.
- Reset low asserted asynchronously mid-lock with a read in flight -> all outputs 0 immediately; after release, the first tie grants c0.
